hist_ram_sched: RTL and testbench

HIST_RAM_SCHED -- requirements
Module: hist_ram_sched

---
 rtl/hist_ram_sched_if.sv | 33 +++
 rtl/hist_ram_sched.sv | 267 ++++++++++++++++++++++++++
 tb/tb_hist_ram_sched.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hist_ram_sched_if.sv
// Histogram scheduler bus bundle: pixel accumulation, bin read-back,
// clear control and the single-port histogram RAM strobes.
interface hist_ram_sched_if;
    logic        acc_valid;
    logic [7:0]  acc_gray;
    logic        acc_ready;
    logic        acc_flush;
    logic        acc_idle;
    logic        rd_req;
    logic [7:0]  rd_addr;
    logic        rd_ack;
    logic [31:0] rd_data;
    logic        clr_start;
    logic        clr_busy;
    logic        clr_done;
    logic        ram_en;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    modport master (
        output acc_valid, acc_gray, acc_flush, rd_req, rd_addr, clr_start, ram_dout,
        input  acc_ready, acc_idle, rd_ack, rd_data, clr_busy, clr_done,
               ram_en, ram_we, ram_addr, ram_din
    );

    modport slave (
        input  acc_valid, acc_gray, acc_flush, rd_req, rd_addr, clr_start, ram_dout,
        output acc_ready, acc_idle, rd_ack, rd_data, clr_busy, clr_done,
               ram_en, ram_we, ram_addr, ram_din
    );
endinterface

// File: rtl/hist_ram_sched.sv
// Histogram RAM scheduler. Pixels of equal gray level are run-length
// collapsed into a pending run (P); a run is committed to the single-port
// histogram RAM by a read-modify-write (saturating add) whenever the gray
// level changes, the run counter would overflow, or a flush is requested.
// Bin read-back and a full 256-bin clear sweep share the same RAM port.
// All RAM strobes and status outputs are registered from next-state values.
module hist_ram_sched (
    input  logic            clk,
    input  logic            rst,
    hist_ram_sched_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FL_RD   = 3'd1,
        ST_FL_WAIT = 3'd2,
        ST_FL_WR   = 3'd3,
        ST_RD_RD   = 3'd4,
        ST_RD_WAIT = 3'd5,
        ST_RD_ACK  = 3'd6,
        ST_CLEAR   = 3'd7
    } state_t;

    // Bin update: base + run length, clamped at the 32-bit maximum.
    function automatic logic [31:0] sat_add(input logic [31:0] base, input logic [15:0] inc);
        logic [32:0] sum;
        sum = {1'b0, base} + {17'd0, inc};
        if (sum[32]) begin
            sat_add = 32'hFFFF_FFFF;
        end else begin
            sat_add = sum[31:0];
        end
    endfunction

    state_t      state_r, state_s;
    logic        p_valid_r, p_valid_s;
    logic [7:0]  p_gray_r, p_gray_s;
    logic [15:0] p_cnt_r, p_cnt_s;
    logic [7:0]  f_gray_r, f_gray_s;
    logic [15:0] f_cnt_r, f_cnt_s;
    logic        clr_lat_r, clr_lat_s;
    logic        flush_pend_r, flush_pend_s;

    logic        ram_en_r, ram_en_s;
    logic        ram_we_r, ram_we_s;
    logic [7:0]  ram_addr_r, ram_addr_s;
    logic [31:0] ram_din_r, ram_din_s;
    logic        rd_ack_r, rd_ack_s;
    logic [31:0] rd_data_r, rd_data_s;
    logic        clr_busy_r, clr_busy_s;
    logic        clr_done_r, clr_done_s;
    logic        acc_ready_r, acc_ready_s;
    logic        acc_idle_r, acc_idle_s;

    logic        accept_s;
    logic        mismatch_s;
    logic        flush_req_s;
    logic        mrg_valid_s;
    logic [7:0]  mrg_gray_s;
    logic [15:0] mrg_cnt_s;

    // Fold an accepted sample into the pending run; flag a run break.
    always_comb begin
        accept_s    = bus.acc_valid && acc_ready_r;
        flush_req_s = bus.acc_flush || flush_pend_r;
        mismatch_s  = 1'b0;
        mrg_valid_s = p_valid_r;
        mrg_gray_s  = p_gray_r;
        mrg_cnt_s   = p_cnt_r;
        if (accept_s) begin
            if (!p_valid_r) begin
                mrg_valid_s = 1'b1;
                mrg_gray_s  = bus.acc_gray;
                mrg_cnt_s   = 16'd1;
            end else if ((bus.acc_gray == p_gray_r) && (p_cnt_r != 16'hFFFF)) begin
                mrg_cnt_s   = p_cnt_r + 16'd1;
            end else begin
                mismatch_s  = 1'b1;
                mrg_valid_s = 1'b1;
                mrg_gray_s  = bus.acc_gray;
                mrg_cnt_s   = 16'd1;
            end
        end else begin
            mismatch_s  = 1'b0;
        end
    end

    // Next-state and next-output decode for the scheduler FSM.
    always_comb begin
        state_s      = state_r;
        p_valid_s    = p_valid_r;
        p_gray_s     = p_gray_r;
        p_cnt_s      = p_cnt_r;
        f_gray_s     = f_gray_r;
        f_cnt_s      = f_cnt_r;
        clr_lat_s    = clr_lat_r || (bus.clr_start && (state_r != ST_CLEAR));
        flush_pend_s = flush_pend_r;
        ram_en_s     = 1'b0;
        ram_we_s     = 1'b0;
        ram_addr_s   = ram_addr_r;
        ram_din_s    = ram_din_r;
        rd_ack_s     = 1'b0;
        rd_data_s    = rd_data_r;
        clr_done_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (clr_lat_r) begin
                    // Clear wins: pending work is dropped, sweep starts at bin 0.
                    state_s      = ST_CLEAR;
                    p_valid_s    = 1'b0;
                    p_gray_s     = 8'd0;
                    p_cnt_s      = 16'd0;
                    f_gray_s     = 8'd0;
                    f_cnt_s      = 16'd0;
                    clr_lat_s    = 1'b0;
                    flush_pend_s = 1'b0;
                    ram_en_s     = 1'b1;
                    ram_we_s     = 1'b1;
                    ram_addr_s   = 8'd0;
                    ram_din_s    = 32'd0;
                end else if (mismatch_s) begin
                    // Run broken: commit the old run, new sample starts P.
                    // A simultaneous flush is remembered for the new run.
                    state_s      = ST_FL_RD;
                    f_gray_s     = p_gray_r;
                    f_cnt_s      = p_cnt_r;
                    p_valid_s    = mrg_valid_s;
                    p_gray_s     = mrg_gray_s;
                    p_cnt_s      = mrg_cnt_s;
                    flush_pend_s = flush_req_s;
                    ram_en_s     = 1'b1;
                    ram_addr_s   = p_gray_r;
                end else if (flush_req_s && mrg_valid_s) begin
                    state_s      = ST_FL_RD;
                    f_gray_s     = mrg_gray_s;
                    f_cnt_s      = mrg_cnt_s;
                    p_valid_s    = 1'b0;
                    p_gray_s     = 8'd0;
                    p_cnt_s      = 16'd0;
                    flush_pend_s = 1'b0;
                    ram_en_s     = 1'b1;
                    ram_addr_s   = mrg_gray_s;
                end else if (bus.rd_req) begin
                    state_s      = ST_RD_RD;
                    p_valid_s    = mrg_valid_s;
                    p_gray_s     = mrg_gray_s;
                    p_cnt_s      = mrg_cnt_s;
                    flush_pend_s = 1'b0;
                    ram_en_s     = 1'b1;
                    ram_addr_s   = bus.rd_addr;
                end else begin
                    p_valid_s    = mrg_valid_s;
                    p_gray_s     = mrg_gray_s;
                    p_cnt_s      = mrg_cnt_s;
                    flush_pend_s = 1'b0;
                end
            end
            ST_FL_RD: begin
                state_s = ST_FL_WAIT;
            end
            ST_FL_WAIT: begin
                // RAM read data is valid now; write back the updated bin.
                state_s    = ST_FL_WR;
                ram_en_s   = 1'b1;
                ram_we_s   = 1'b1;
                ram_addr_s = f_gray_r;
                ram_din_s  = sat_add(bus.ram_dout, f_cnt_r);
            end
            ST_FL_WR: begin
                state_s = ST_IDLE;
            end
            ST_RD_RD: begin
                state_s = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                state_s   = ST_RD_ACK;
                rd_ack_s  = 1'b1;
                rd_data_s = bus.ram_dout;
            end
            ST_RD_ACK: begin
                state_s = ST_IDLE;
            end
            ST_CLEAR: begin
                p_valid_s    = 1'b0;
                flush_pend_s = 1'b0;
                clr_lat_s    = 1'b0;
                if (ram_addr_r == 8'hFF) begin
                    state_s    = ST_IDLE;
                    clr_done_s = 1'b1;
                end else begin
                    ram_en_s   = 1'b1;
                    ram_we_s   = 1'b1;
                    ram_addr_s = ram_addr_r + 8'd1;
                    ram_din_s  = 32'd0;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        acc_ready_s = (state_s == ST_IDLE) && !clr_lat_s;
        acc_idle_s  = (state_s == ST_IDLE) && !p_valid_s && !flush_pend_s;
        clr_busy_s  = (state_s == ST_CLEAR);
    end

    // State, pending run, flush run and clear latch registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            p_valid_r    <= 1'b0;
            p_gray_r     <= 8'd0;
            p_cnt_r      <= 16'd0;
            f_gray_r     <= 8'd0;
            f_cnt_r      <= 16'd0;
            clr_lat_r    <= 1'b0;
            flush_pend_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            p_valid_r    <= p_valid_s;
            p_gray_r     <= p_gray_s;
            p_cnt_r      <= p_cnt_s;
            f_gray_r     <= f_gray_s;
            f_cnt_r      <= f_cnt_s;
            clr_lat_r    <= clr_lat_s;
            flush_pend_r <= flush_pend_s;
        end
    end

    // Registered outputs; reset drops every strobe at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_en_r    <= 1'b0;
            ram_we_r    <= 1'b0;
            ram_addr_r  <= 8'd0;
            ram_din_r   <= 32'd0;
            rd_ack_r    <= 1'b0;
            rd_data_r   <= 32'd0;
            clr_busy_r  <= 1'b0;
            clr_done_r  <= 1'b0;
            acc_ready_r <= 1'b0;
            acc_idle_r  <= 1'b1;
        end else begin
            ram_en_r    <= ram_en_s;
            ram_we_r    <= ram_we_s;
            ram_addr_r  <= ram_addr_s;
            ram_din_r   <= ram_din_s;
            rd_ack_r    <= rd_ack_s;
            rd_data_r   <= rd_data_s;
            clr_busy_r  <= clr_busy_s;
            clr_done_r  <= clr_done_s;
            acc_ready_r <= acc_ready_s;
            acc_idle_r  <= acc_idle_s;
        end
    end

    assign bus.ram_en    = ram_en_r;
    assign bus.ram_we    = ram_we_r;
    assign bus.ram_addr  = ram_addr_r;
    assign bus.ram_din   = ram_din_r;
    assign bus.rd_ack    = rd_ack_r;
    assign bus.rd_data   = rd_data_r;
    assign bus.clr_busy  = clr_busy_r;
    assign bus.clr_done  = clr_done_r;
    assign bus.acc_ready = acc_ready_r;
    assign bus.acc_idle  = acc_idle_r;

endmodule

// File: tb/tb_hist_ram_sched.sv
// Directed bench for hist_ram_sched with a behavioural single-port RAM.
module tb_hist_ram_sched;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hist_ram_sched_if bus ();
    hist_ram_sched dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    logic [31:0] mem [0:255];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = 8'd0;
    logic [31:0] pl_data = 32'd0;
    wr_t         wr_q [$];

    // RAM model: read data appears the cycle after the enable cycle; logs writes.
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (bus.ram_en) begin
            if (bus.ram_we) begin
                mem[bus.ram_addr] <= bus.ram_din;
                wr_q.push_back(wr_t'{a: bus.ram_addr, d: bus.ram_din});
            end else begin
                bus.ram_dout <= mem[bus.ram_addr];
            end
        end
    end

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic send(input logic [7:0] g, output bit ok);
        bit rdy;
        int n;
        bus.acc_valid = 1'b1;
        bus.acc_gray  = g;
        n = 0;
        do begin
            rdy = bus.acc_ready;
            @(posedge clk); @(negedge clk);
            n++;
        end while (!rdy && n < 50);
        bus.acc_valid = 1'b0;
        ok = rdy;
    endtask

    task automatic do_flush(output bit ok);
        int n;
        n = 0;
        while (!bus.acc_ready && n < 50) begin @(negedge clk); n++; end
        bus.acc_flush = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.acc_flush = 1'b0;
        n = 0;
        while (!bus.acc_idle && n < 50) begin @(negedge clk); n++; end
        ok = bus.acc_idle;
    endtask

    task automatic read_bin(input logic [7:0] a, output int lat, output logic [31:0] d);
        bus.rd_req  = 1'b1;
        bus.rd_addr = a;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!bus.rd_ack && lat < 20);
        d = bus.rd_data;
        bus.rd_req = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.clr_start = 1'b1;
        @(negedge clk);
        bus.clr_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.ram_en !== 1'b0) begin n_fail++; $display("FAIL rst_ram_en: got %b want 0", bus.ram_en); end
        n_checks++; if (bus.acc_ready !== 1'b0) begin n_fail++; $display("FAIL rst_acc_ready: got %b want 0", bus.acc_ready); end
        n_checks++; if (bus.acc_idle !== 1'b1) begin n_fail++; $display("FAIL rst_acc_idle: got %b want 1", bus.acc_idle); end
        n_checks++; if ({bus.clr_busy, bus.clr_done, bus.rd_ack} !== 3'b000) begin n_fail++; $display("FAIL rst_status: got %b want 000", {bus.clr_busy, bus.clr_done, bus.rd_ack}); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.acc_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b want 1", bus.acc_ready); end
    endtask

    task automatic test_clear();
        int nb, nd, bad, mark;
        mark = wr_q.size();
        pulse_clr();
        nb = 0; nd = 0;
        for (int i = 0; i < 300; i++) begin
            if (bus.clr_busy) nb++;
            if (bus.clr_done) nd++;
            @(negedge clk);
        end
        n_checks++; if (nb !== 256) begin n_fail++; $display("FAIL clr_busy_cycles: got %0d want 256", nb); end
        n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL clr_done_pulses: got %0d want 1", nd); end
        n_checks++; if (wr_q.size() - mark !== 256) begin n_fail++; $display("FAIL clr_writes: got %0d want 256", wr_q.size() - mark); end
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (mark + i < wr_q.size()) begin
                if (wr_q[mark+i].a !== i[7:0] || wr_q[mark+i].d !== 32'd0) bad++;
            end else begin
                bad++;
            end
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL clr_sequence: got %0d bad entries want 0", bad); end
    endtask

    task automatic test_hist();
        bit ok, all_ok;
        int mark;
        preload(8'd5, 32'd10);
        preload(8'd3, 32'hFFFF_FFF0);
        mark = wr_q.size();
        all_ok = 1'b1;
        send(8'd5, ok); all_ok &= ok;
        send(8'd5, ok); all_ok &= ok;
        send(8'd5, ok); all_ok &= ok;
        send(8'd7, ok); all_ok &= ok;
        do_flush(ok); all_ok &= ok;
        n_checks++; if (all_ok !== 1'b1) begin n_fail++; $display("FAIL hist_handshake: got %b want 1", all_ok); end
        n_checks++; if (wr_q.size() - mark !== 2) begin n_fail++; $display("FAIL hist_writes: got %0d want 2", wr_q.size() - mark); end
        if (wr_q.size() >= mark + 2) begin
            n_checks++; if (wr_q[mark] !== wr_t'{a: 8'd5, d: 32'd13}) begin n_fail++; $display("FAIL hist_wr0: got a=%0d d=%0d want a=5 d=13", wr_q[mark].a, wr_q[mark].d); end
            n_checks++; if (wr_q[mark+1] !== wr_t'{a: 8'd7, d: 32'd1}) begin n_fail++; $display("FAIL hist_wr1: got a=%0d d=%0d want a=7 d=1", wr_q[mark+1].a, wr_q[mark+1].d); end
        end
        n_checks++; if (bus.acc_idle !== 1'b1) begin n_fail++; $display("FAIL hist_idle: got %b want 1", bus.acc_idle); end
        // 32 hits on a bin holding 0xFFFFFFF0 must clamp.
        mark = wr_q.size();
        all_ok = 1'b1;
        for (int i = 0; i < 32; i++) begin send(8'd3, ok); all_ok &= ok; end
        do_flush(ok); all_ok &= ok;
        n_checks++; if (wr_q.size() - mark !== 1 || !all_ok) begin n_fail++; $display("FAIL sat_writes: got %0d ok=%b want 1 ok=1", wr_q.size() - mark, all_ok); end
        n_checks++; if (mem[3] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_bin3: got %h want ffffffff", mem[3]); end
    endtask

    task automatic test_read();
        int lat;
        logic [31:0] d;
        read_bin(8'd5, lat, d);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL rd5_latency: got %0d want 3", lat); end
        n_checks++; if (d !== 32'd13) begin n_fail++; $display("FAIL rd5_data: got %0d want 13", d); end
        @(negedge clk);
        n_checks++; if (bus.rd_ack !== 1'b0) begin n_fail++; $display("FAIL rd_ack_width: got %b want 0", bus.rd_ack); end
        read_bin(8'd7, lat, d);
        n_checks++; if (d !== 32'd1 || lat !== 3) begin n_fail++; $display("FAIL rd7: got d=%0d lat=%0d want d=1 lat=3", d, lat); end
        @(negedge clk);
    endtask

    task automatic test_long_run();
        bit ok, all_ok;
        int mark;
        mark = wr_q.size();
        all_ok = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            send(8'd9, ok);
            if (!ok) begin all_ok = 1'b0; break; end
        end
        if (all_ok) begin do_flush(ok); all_ok &= ok; end
        n_checks++; if (all_ok !== 1'b1) begin n_fail++; $display("FAIL long_handshake: got %b want 1", all_ok); end
        n_checks++; if (wr_q.size() - mark !== 2) begin n_fail++; $display("FAIL long_writes: got %0d want 2", wr_q.size() - mark); end
        if (wr_q.size() >= mark + 2) begin
            n_checks++; if (wr_q[mark] !== wr_t'{a: 8'd9, d: 32'd65535}) begin n_fail++; $display("FAIL long_wr0: got a=%0d d=%0d want a=9 d=65535", wr_q[mark].a, wr_q[mark].d); end
        end
        n_checks++; if (mem[9] !== 32'd70000) begin n_fail++; $display("FAIL long_bin9: got %0d want 70000", mem[9]); end
    endtask

    task automatic test_clr_mid_flush();
        bit ok, all_ok;
        int mark, nb, nd, bad;
        logic idle_at_done;
        mark = wr_q.size();
        all_ok = 1'b1;
        send(8'd20, ok); all_ok &= ok;
        send(8'd21, ok); all_ok &= ok;   // now in FL_RD
        @(negedge clk);                  // FL_WAIT
        pulse_clr();                     // now in FL_WR
        nb = 0; nd = 0; idle_at_done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (bus.clr_busy) nb++;
            if (bus.clr_done) begin nd++; idle_at_done = bus.acc_idle; end
            @(negedge clk);
        end
        n_checks++; if (all_ok !== 1'b1) begin n_fail++; $display("FAIL cmf_handshake: got %b want 1", all_ok); end
        n_checks++; if (nb !== 256 || nd !== 1) begin n_fail++; $display("FAIL cmf_sweep: got busy=%0d done=%0d want 256/1", nb, nd); end
        n_checks++; if (idle_at_done !== 1'b1) begin n_fail++; $display("FAIL cmf_idle_at_done: got %b want 1", idle_at_done); end
        n_checks++; if (wr_q.size() - mark !== 257) begin n_fail++; $display("FAIL cmf_writes: got %0d want 257", wr_q.size() - mark); end
        bad = 0;
        if (wr_q.size() >= mark + 257) begin
            if (wr_q[mark] !== wr_t'{a: 8'd20, d: 32'd1}) bad++;
            for (int i = 0; i < 256; i++)
                if (wr_q[mark+1+i].a !== i[7:0] || wr_q[mark+1+i].d !== 32'd0) bad++;
        end else begin
            bad = 1;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL cmf_sequence: got %0d bad entries want 0", bad); end
    endtask

    task automatic test_rst_mid_sweep();
        int n, nd, mark;
        preload(8'd200, 32'd77);
        pulse_clr();
        n = 0;
        while (!(bus.ram_en && bus.ram_we && bus.ram_addr == 8'd100) && n < 400) begin @(negedge clk); n++; end
        n_checks++; if (bus.ram_addr !== 8'd100) begin n_fail++; $display("FAIL rms_reach100: got %0d want 100", bus.ram_addr); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if ({bus.ram_en, bus.clr_busy, bus.clr_done} !== 3'b000) begin n_fail++; $display("FAIL rms_abandon: got %b want 000", {bus.ram_en, bus.clr_busy, bus.clr_done}); end
        rst = 1'b1;
        mark = wr_q.size();
        nd = 0;
        repeat (300) begin @(negedge clk); if (bus.clr_done) nd++; end
        n_checks++; if (nd !== 0 || wr_q.size() - mark !== 0) begin n_fail++; $display("FAIL rms_no_resume: got done=%0d writes=%0d want 0/0", nd, wr_q.size() - mark); end
        n_checks++; if (mem[200] !== 32'd77) begin n_fail++; $display("FAIL rms_bin200: got %0d want 77", mem[200]); end
        n_checks++; if ({bus.acc_ready, bus.acc_idle} !== 2'b11) begin n_fail++; $display("FAIL rms_after: got %b want 11", {bus.acc_ready, bus.acc_idle}); end
    endtask

    initial begin
        bus.acc_valid = 1'b0;
        bus.acc_gray  = 8'd0;
        bus.acc_flush = 1'b0;
        bus.rd_req    = 1'b0;
        bus.rd_addr   = 8'd0;
        bus.clr_start = 1'b0;
        bus.ram_dout  = 32'd0;
        rst           = 1'b0;
        @(negedge clk);
        test_reset();
        test_clear();
        test_hist();
        test_read();
        test_long_run();
        test_clr_mid_flush();
        test_rst_mid_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
